// File: rtl/vc_flit_buffer_ctrl_if.sv
// Link / switch-allocator / RAM-side signal bundle for the VC flit buffer controller.
// master: the surrounding router logic that issues requests and consumes status.
// slave:  the controller itself.
interface vc_flit_buffer_ctrl_if #(
    parameter int V  = 4,
    parameter int B  = 4,
    parameter int Fw = 32
);
    localparam int VW = $clog2(V);
    localparam int BW = $clog2(B);
    localparam int AW = VW + BW;

    logic [Fw-1:0] flit_in;
    logic          flit_in_wr;
    logic [V-1:0]  vc_num_wr;
    logic          rd_req;
    logic [V-1:0]  vc_num_rd;

    logic [Fw-1:0] ram_wr_data;
    logic [AW-1:0] ram_wr_addr;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_wr_en;
    logic          ram_rd_en;

    logic [V-1:0]  vc_not_empty;
    logic [V-1:0]  vc_full;
    logic          flit_out_valid;
    logic [V-1:0]  flit_out_vc;
    logic          err_ovf;
    logic          err_udf;

    modport master (
        output flit_in, flit_in_wr, vc_num_wr, rd_req, vc_num_rd,
        input  ram_wr_data, ram_wr_addr, ram_rd_addr, ram_wr_en, ram_rd_en,
        input  vc_not_empty, vc_full, flit_out_valid, flit_out_vc, err_ovf, err_udf
    );

    modport slave (
        input  flit_in, flit_in_wr, vc_num_wr, rd_req, vc_num_rd,
        output ram_wr_data, ram_wr_addr, ram_rd_addr, ram_wr_en, ram_rd_en,
        output vc_not_empty, vc_full, flit_out_valid, flit_out_vc, err_ovf, err_udf
    );
endinterface

// File: rtl/vc_flit_buffer_ctrl.sv
// Per-VC pointer/occupancy controller for a router input-port flit buffer.
// One shared dual-port RAM of V*B entries is split into V circular queues of
// B flits; the VC index forms the upper address bits. Status flags come from
// registered counts only, so a same-cycle write never makes a read of an empty
// VC succeed and a same-cycle read never makes room for a write to a full VC.
module vc_flit_buffer_ctrl #(
    parameter int V  = 4,
    parameter int B  = 4,
    parameter int Fw = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    vc_flit_buffer_ctrl_if.slave   bus
);
    localparam int VW = $clog2(V);
    localparam int BW = $clog2(B);
    localparam int AW = VW + BW;
    localparam logic [BW:0] CNT_FULL = (BW+1)'(B);

    // Lowest set bit wins when a VC vector is not one-hot.
    function automatic logic [VW-1:0] lowest_idx(input logic [V-1:0] vec);
        lowest_idx = '0;
        for (int i = V - 1; i >= 0; i--) begin
            if (vec[i]) lowest_idx = VW'(i);
        end
    endfunction

    logic [BW-1:0] wr_ptr_q [V];
    logic [BW-1:0] wr_ptr_d [V];
    logic [BW-1:0] rd_ptr_q [V];
    logic [BW-1:0] rd_ptr_d [V];
    logic [BW:0]   cnt_q    [V];
    logic [BW:0]   cnt_d    [V];

    logic [V-1:0]  not_empty_q, not_empty_d;
    logic [V-1:0]  full_q, full_d;
    logic          out_valid_q;
    logic [V-1:0]  out_vc_q;
    logic          err_ovf_q, err_udf_q;

    logic [VW-1:0] w_idx, r_idx;
    logic          w_req, r_req;
    logic          wa, ra;

    assign w_idx = lowest_idx(bus.vc_num_wr);
    assign r_idx = lowest_idx(bus.vc_num_rd);
    assign w_req = bus.flit_in_wr & (|bus.vc_num_wr);
    assign r_req = bus.rd_req & (|bus.vc_num_rd);

    // Accepts are blocked while reset is held so the RAM sees no strobes.
    assign wa = w_req & ~full_q[w_idx] & ~reset;
    assign ra = r_req & not_empty_q[r_idx] & ~reset;

    assign bus.ram_wr_en    = wa;
    assign bus.ram_rd_en    = ra;
    assign bus.ram_wr_data  = bus.flit_in;
    assign bus.ram_wr_addr  = AW'({w_idx, wr_ptr_q[w_idx]});
    assign bus.ram_rd_addr  = AW'({r_idx, rd_ptr_q[r_idx]});

    assign bus.vc_not_empty   = not_empty_q;
    assign bus.vc_full        = full_q;
    assign bus.flit_out_valid = out_valid_q;
    assign bus.flit_out_vc    = out_vc_q;
    assign bus.err_ovf        = err_ovf_q;
    assign bus.err_udf        = err_udf_q;

    // Next pointer/count per VC; a write and read hitting the same VC leave cnt unchanged.
    always_comb begin
        for (int i = 0; i < V; i++) begin
            wr_ptr_d[i]    = wr_ptr_q[i];
            rd_ptr_d[i]    = rd_ptr_q[i];
            cnt_d[i]       = cnt_q[i];
            not_empty_d[i] = 1'b0;
            full_d[i]      = 1'b0;

            if (wa && (w_idx == VW'(i))) begin
                wr_ptr_d[i] = wr_ptr_q[i] + BW'(1);
            end
            if (ra && (r_idx == VW'(i))) begin
                rd_ptr_d[i] = rd_ptr_q[i] + BW'(1);
            end

            if ((wa && (w_idx == VW'(i))) && !(ra && (r_idx == VW'(i)))) begin
                cnt_d[i] = cnt_q[i] + (BW+1)'(1);
            end else if ((ra && (r_idx == VW'(i))) && !(wa && (w_idx == VW'(i)))) begin
                cnt_d[i] = cnt_q[i] - (BW+1)'(1);
            end

            not_empty_d[i] = (cnt_d[i] != '0);
            full_d[i]      = (cnt_d[i] == CNT_FULL);
        end
    end

    // State register: pointers, counts, registered status, read tag and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            not_empty_q <= '0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < V; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            not_empty_q <= not_empty_d;
            full_q      <= full_d;
            out_valid_q <= ra;
            out_vc_q    <= ra ? (V'(1) << r_idx) : '0;
            err_ovf_q   <= err_ovf_q | (w_req & full_q[w_idx]);
            err_udf_q   <= err_udf_q | (r_req & ~not_empty_q[r_idx]);
        end
    end
endmodule

// File: tb/tb_vc_flit_buffer_ctrl.sv
// Bench for vc_flit_buffer_ctrl: behavioural read-first RAM on the address
// strobes, a reference model of the per-VC queues, and a scoreboard of
// expected read data/tags popped when flit_out_valid appears.
module tb_vc_flit_buffer_ctrl;
    localparam int V  = 4;
    localparam int B  = 4;
    localparam int Fw = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_flit_buffer_ctrl_if #(.V(V), .B(B), .Fw(Fw)) bus ();

    vc_flit_buffer_ctrl #(.V(V), .B(B), .Fw(Fw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Read-first RAM with 1-cycle read latency.
    logic [Fw-1:0] ram [V*B];
    logic [Fw-1:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_rd_en) ram_q <= ram[bus.ram_rd_addr];
        if (bus.ram_wr_en) ram[bus.ram_wr_addr] <= bus.ram_wr_data;
    end

    int            m_cnt [V];
    int            m_wp  [V];
    int            m_rp  [V];
    logic [Fw-1:0] m_mem [V][B];
    logic          m_ovf, m_udf;
    logic          pend_valid;
    logic [Fw-1:0] sb_data [$];
    int            sb_vc   [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lsb(input logic [V-1:0] vec);
        lsb = -1;
        for (int i = V - 1; i >= 0; i--) if (vec[i]) lsb = i;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < V; i++) begin
            m_cnt[i] = 0;
            m_wp[i]  = 0;
            m_rp[i]  = 0;
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
        pend_valid = 1'b0;
        sb_data.delete();
        sb_vc.delete();
    endtask

    // Registered outputs, checked mid-cycle (at negedge).
    task automatic check_state();
        logic [V-1:0] ne, fu;
        logic [Fw-1:0] exp_d;
        int exp_vc;
        for (int i = 0; i < V; i++) begin
            ne[i] = (m_cnt[i] != 0);
            fu[i] = (m_cnt[i] == B);
        end
        check_eq("vc_not_empty", bus.vc_not_empty, ne);
        check_eq("vc_full", bus.vc_full, fu);
        check_eq("err_ovf", bus.err_ovf, m_ovf);
        check_eq("err_udf", bus.err_udf, m_udf);
        check_eq("flit_out_valid", bus.flit_out_valid, pend_valid);
        if (pend_valid) begin
            exp_d  = sb_data.pop_front();
            exp_vc = sb_vc.pop_front();
            check_eq("flit_out_vc", bus.flit_out_vc, 64'(1) << exp_vc);
            check_eq("flit_data", ram_q, exp_d);
        end
    endtask

    task automatic cyc(input logic wr, input logic [V-1:0] wv, input logic [Fw-1:0] d,
                       input logic rd, input logic [V-1:0] rv);
        int wi, ri;
        logic ewa, era;
        check_state();
        bus.flit_in_wr = wr;
        bus.vc_num_wr  = wv;
        bus.flit_in    = d;
        bus.rd_req     = rd;
        bus.vc_num_rd  = rv;
        wi = lsb(wv);
        ri = lsb(rv);
        if (wr && wi >= 0) ewa = (m_cnt[wi] != B); else ewa = 1'b0;
        if (rd && ri >= 0) era = (m_cnt[ri] != 0); else era = 1'b0;
        #1;
        check_eq("ram_wr_en", bus.ram_wr_en, ewa);
        if (ewa) begin
            check_eq("ram_wr_addr", bus.ram_wr_addr, wi * B + m_wp[wi]);
            check_eq("ram_wr_data", bus.ram_wr_data, d);
        end
        check_eq("ram_rd_en", bus.ram_rd_en, era);
        if (era) check_eq("ram_rd_addr", bus.ram_rd_addr, ri * B + m_rp[ri]);

        if (wr && wi >= 0 && !ewa) m_ovf = 1'b1;
        if (rd && ri >= 0 && !era) m_udf = 1'b1;
        pend_valid = era;
        if (era) begin
            sb_data.push_back(m_mem[ri][m_rp[ri]]);
            sb_vc.push_back(ri);
            m_rp[ri] = (m_rp[ri] + 1) % B;
            m_cnt[ri]--;
        end
        if (ewa) begin
            m_mem[wi][m_wp[wi]] = d;
            m_wp[wi] = (m_wp[wi] + 1) % B;
            m_cnt[wi]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic reset_with_req(input logic [V-1:0] vc);
        check_state();
        reset = 1'b1;
        bus.rd_req     = 1'b1;
        bus.vc_num_rd  = vc;
        bus.flit_in_wr = 1'b1;
        bus.vc_num_wr  = vc;
        bus.flit_in    = 32'hDEAD_BEEF;
        #1;
        check_eq("rst_ram_rd_en", bus.ram_rd_en, 1'b0);
        check_eq("rst_ram_wr_en", bus.ram_wr_en, 1'b0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.rd_req     = 1'b0;
        bus.vc_num_rd  = '0;
        bus.flit_in_wr = 1'b0;
        bus.vc_num_wr  = '0;
        bus.flit_in    = '0;
    endtask

    initial begin
        logic wr, rd;
        bus.flit_in    = '0;
        bus.flit_in_wr = 1'b0;
        bus.vc_num_wr  = '0;
        bus.rd_req     = 1'b0;
        bus.vc_num_rd  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state();
        reset = 1'b0;

        // 1: three writes to VC2 -> addresses 8,9,10
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0100, 32'hA0 + i, 1'b0, '0);

        // 2: three back-to-back reads of VC2
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 4'b0100);
        idle();

        // 3: fill VC0, overflow, then simultaneous read+write on the full VC
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0001, 32'hB0 + i, 1'b0, '0);
        cyc(1'b1, 4'b0001, 32'hB4, 1'b0, '0);
        cyc(1'b1, 4'b0001, 32'hC0, 1'b1, 4'b0001);
        idle();

        // 4: read+write on empty VC3, then read succeeds
        cyc(1'b1, 4'b1000, 32'hD0, 1'b1, 4'b1000);
        cyc(1'b0, '0, '0, 1'b1, 4'b1000);
        idle();

        // Non-one-hot selects lowest bit; all-zero vector is no request
        cyc(1'b1, 4'b0110, 32'hE0, 1'b0, '0);
        cyc(1'b1, 4'b0000, 32'hE1, 1'b1, 4'b0000);
        cyc(1'b0, '0, '0, 1'b1, 4'b1010);

        // 5: interleaved writes to VC1 and reads of VC0 with random gaps
        for (int k = 0; k < 20; k++) begin
            wr = ($urandom_range(0, 1) == 1) && (m_cnt[1] < B);
            rd = ($urandom_range(0, 1) == 1) && (m_cnt[0] > 0);
            cyc(wr, 4'b0010, 32'h100 + k, rd, 4'b0001);
        end
        idle();

        // 6: VC1 holds 2 flits with a read pending, reset asserted with a read
        while (m_cnt[1] > 3) cyc(1'b0, '0, '0, 1'b1, 4'b0010);
        while (m_cnt[1] < 3) cyc(1'b1, 4'b0010, 32'h200 + m_cnt[1], 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 4'b0010);
        reset_with_req(4'b0010);
        idle();
        cyc(1'b0, '0, '0, 1'b1, 4'b0010);
        idle();
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
